data_bus_responder: RTL and testbench
=====================================

// Module: data_bus_responder
// PURPOSE
// - Responder (slave) end of the CPU data bus. The ControlUnit drives the
//   data_cyc/data_stb/data_we/port_we strobes; this block completes them.
// - Holds a word-addressed data RAM and returns data_ack_o after a
//   programmable number of wait states.
// - Sits between the datapath load/store path and the CPU memory space.
// PARAMETERS
// - DATA_W       16   data word width
// - ADDR_W       8    address width (word address)
// - DEPTH        256  implemented words, 1..2**ADDR_W
// - WAIT_STATES  1    extra cycles before ack, 0..15
// PORTS
// - clk          in   1       rising-edge clock
// - rst          in   1       reset: synchronous, active-low
// - data_cyc_i   in   1       bus cycle in progress
// - data_stb_i   in   1       transfer strobe
// - data_we_i    in   1       1 = write, 0 = read
// - port_we_i    in   1       selects the output port instead of RAM
// - data_addr_i  in   ADDR_W  word address
// - data_i       in   DATA_W  write data
// - data_o       out  DATA_W  read data, valid while data_ack_o = 1
// - data_ack_o   out  1       one-cycle transfer acknowledge
// - port_o       out  DATA_W  output port register
// - busy_o       out  1       1 when state != IDLE
// BEHAVIOUR
// - Reset (rst = 0 at a clk edge):
//   - state = IDLE; data_ack_o, data_o, port_o, busy_o = 0; counter = 0.
//   - RAM contents are not cleared.
// - States: IDLE, WAIT, ACK. Every transition is registered.
// - IDLE
//   - At an edge where cyc & stb = 1, latch addr, we, data_i and port_we.
//   - If WAIT_STATES = 0, go to ACK; otherwise load cnt = WAIT_STATES and go to WAIT.
// - WAIT
//   - cnt decrements every edge. At the edge where cnt = 1, go to ACK.
//   - If cyc = 0 at any WAIT edge, abort: go to IDLE with no ack and no write.
// - ACK
//   - data_ack_o = 1 for exactly one cycle, then IDLE unconditionally.
// - Latency: request sampled at edge T0; data_ack_o is high during the cycle
//   after edge T0+WAIT_STATES.
// - Back-to-back: a request still asserted during the ACK cycle is not taken.
//   It is sampled at the first IDLE edge, so there is at least one idle cycle
//   between acks.
// - Write: RAM[addr] <= data at the edge entering ACK. It is committed even if
//   cyc drops during the ACK cycle.
// - Read: data_o <= RAM[addr] at the edge entering ACK. data_o holds its value
//   until the next ACK entry.
// - Out of range (addr >= DEPTH): the write is dropped, a read returns 0, and
//   the ack is still given.
// - stb = 1 with cyc = 0 is ignored. Bus inputs are don't-care outside IDLE,
//   except cyc for abort.
// - Reset mid-transfer: the next edge with rst = 0 returns the block to IDLE.
//   No ack and no write occur for that transfer.
// CONFIGURATION
// - Macro DATA_RESP_PORT_EN.
// - Defined:
//   - A write with port_we latched = 1 updates port_o at the edge entering ACK;
//     RAM is untouched.
//   - A read with port_we latched = 1 returns port_o on data_o.
//   - The address is ignored for port accesses.
// - Undefined:
//   - port_we_i is ignored and every access goes to RAM.
//   - port_o is tied to 0.
// TESTING
// - Reset: drive rst = 0 for 3 edges during a WAIT -> all outputs 0, state IDLE;
//   a later read of the address shows no write was committed.
// - WAIT_STATES = 1: write 0xBEEF to addr 0x05 and sample ack timing
//   -> ack high in the cycle after T0+1, exactly 1 cycle wide.
//   Then read 0x05 -> data_o = 0xBEEF.
// - WAIT_STATES = 0: write 0x1234 to 0x00, then read 0x00 -> ack after T0 each time;
//   data_o = 0x1234; one idle cycle between the two acks.
// - Abort: WAIT_STATES = 3, write 0xAAAA to 0x10, drop cyc after 1 cycle
//   -> no ack; a read of 0x10 returns the previous value.
// - DEPTH = 16: write 0x5555 to addr 0x20 -> ack given;
//   a read of 0x20 returns 0x0000.
// - DATA_RESP_PORT_EN: write 0x00F0 with port_we = 1 -> port_o = 0x00F0 and
//   RAM[addr] unchanged. Read with port_we = 1 -> data_o = 0x00F0.
//   Macro undefined -> port_o stays 0.

Source files
------------

// File: rtl/data_bus_responder.sv
// Responder end of the CPU data bus: word RAM with programmable wait states before a one-cycle ack.
// Optional output-port register enabled by defining DATA_RESP_PORT_EN.
module data_bus_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_cyc_i,
  input  logic              data_stb_i,
  input  logic              data_we_i,
  input  logic              port_we_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_ack_o,
  output logic [DATA_W-1:0] port_o,
  output logic              busy_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              commit;
  logic              req, in_idle;
  logic [ADDR_W-1:0] addr_q, eff_addr;
  logic [DATA_W-1:0] wdata_q, eff_data;
  logic              we_q, eff_we;
  logic              in_range, port_sel;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] mem [DEPTH];

  assign req     = data_cyc_i & data_stb_i;
  assign in_idle = (state == IDLE);

  // With zero wait states the commit happens on the accepting edge, so use the live bus.
  assign eff_addr = in_idle ? data_addr_i : addr_q;
  assign eff_data = in_idle ? data_i      : wdata_q;
  assign eff_we   = in_idle ? data_we_i   : we_q;
  assign in_range = 32'(eff_addr) < 32'(DEPTH);
  assign idx      = eff_addr[AW-1:0];

`ifdef DATA_RESP_PORT_EN
  logic              pw_q;
  logic [DATA_W-1:0] port_q;
  assign port_sel = in_idle ? port_we_i : pw_q;
  assign port_o   = port_q;
`else
  logic unused_port_we;
  assign unused_port_we = port_we_i;
  assign port_sel       = 1'b0;
  assign port_o         = '0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: if (req) begin
        if (WAIT_STATES == 0) begin
          state_nxt = ACK;
          commit    = 1'b1;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = 4'(WAIT_STATES);
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (!data_cyc_i) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == 4'd1) begin
          state_nxt = ACK;
          commit    = 1'b1;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      data_o  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
`ifdef DATA_RESP_PORT_EN
      pw_q    <= 1'b0;
      port_q  <= '0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (in_idle && req) begin
        addr_q  <= data_addr_i;
        wdata_q <= data_i;
        we_q    <= data_we_i;
`ifdef DATA_RESP_PORT_EN
        pw_q    <= port_we_i;
`endif
      end
      if (commit && !eff_we) begin
`ifdef DATA_RESP_PORT_EN
        if (port_sel) data_o <= port_q;
        else
`endif
        data_o <= in_range ? mem[idx] : '0;
      end
`ifdef DATA_RESP_PORT_EN
      if (commit && eff_we && port_sel) port_q <= eff_data;
`endif
    end
  end

  // RAM is never cleared; out-of-range writes are silently dropped.
  always_ff @(posedge clk) begin
    if (rst && commit && eff_we && in_range && !port_sel) mem[idx] <= eff_data;
  end

  assign data_ack_o = (state == ACK);
  assign busy_o     = !in_idle;

endmodule

// File: tb/tb_data_bus_responder.sv
// Drives three responder configurations from one shared bus and checks them against a transaction-timing model.
module tb_data_bus_responder;

`ifdef DATA_RESP_PORT_EN
  localparam bit PORT_EN = 1'b1;
`else
  localparam bit PORT_EN = 1'b0;
`endif
  localparam int WS [3] = '{1, 0, 3};
  localparam int DP [3] = '{256, 256, 16};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0, pw = 1'b0;
  logic [7:0]  addr = '0;
  logic [15:0] wdat = '0;
  logic [2:0]       ack, busy;
  logic [2:0][15:0] dout, pout;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  data_bus_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(1)) u_a (
    .clk(clk), .rst(rst), .data_cyc_i(cyc), .data_stb_i(stb), .data_we_i(we), .port_we_i(pw),
    .data_addr_i(addr), .data_i(wdat), .data_o(dout[0]), .data_ack_o(ack[0]), .port_o(pout[0]), .busy_o(busy[0]));
  data_bus_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(0)) u_b (
    .clk(clk), .rst(rst), .data_cyc_i(cyc), .data_stb_i(stb), .data_we_i(we), .port_we_i(pw),
    .data_addr_i(addr), .data_i(wdat), .data_o(dout[1]), .data_ack_o(ack[1]), .port_o(pout[1]), .busy_o(busy[1]));
  data_bus_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(16), .WAIT_STATES(3)) u_c (
    .clk(clk), .rst(rst), .data_cyc_i(cyc), .data_stb_i(stb), .data_we_i(we), .port_we_i(pw),
    .data_addr_i(addr), .data_i(wdat), .data_o(dout[2]), .data_ack_o(ack[2]), .port_o(pout[2]), .busy_o(busy[2]));

  // Model: a request accepted at edge t0 commits at edge t0+WS and acks until edge t0+WS+1.
  int          edge_n = 0;
  bit          inited [3];
  bit          pend [3];
  int          t0 [3];
  int          ack_end [3];
  bit          l_we [3], l_pw [3];
  logic [7:0]  l_addr [3];
  logic [15:0] l_data [3];
  logic [15:0] m_dout [3], m_port [3];
  bit          m_dk [3];
  logic [15:0] mem [3][256];
  bit          mk [3][256];

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, k, act, exp, $time);
    end
  endtask

  task automatic commit_m(input int k, input bit w, input bit p, input logic [7:0] a, input logic [15:0] d);
    if (PORT_EN && p) begin
      if (w) m_port[k] = d;
      else begin m_dout[k] = m_port[k]; m_dk[k] = 1'b1; end
    end else if (w) begin
      if (int'(a) < DP[k]) begin mem[k][a] = d; mk[k][a] = 1'b1; end
    end else if (int'(a) < DP[k]) begin
      m_dout[k] = mem[k][a]; m_dk[k] = mk[k][a];
    end else begin
      m_dout[k] = 16'h0; m_dk[k] = 1'b1;
    end
  endtask

  task automatic model_step(input int k);
    if (!rst) begin
      inited[k] = 1'b1; pend[k] = 1'b0; ack_end[k] = -1;
      m_dout[k] = 16'h0; m_dk[k] = 1'b1; m_port[k] = 16'h0;
    end else if (!inited[k]) begin
      // state unknown until the first reset
    end else if (ack_end[k] == edge_n) begin
      ack_end[k] = -1;
    end else if (pend[k]) begin
      if (!cyc) pend[k] = 1'b0;
      else if (edge_n == t0[k] + WS[k]) begin
        commit_m(k, l_we[k], l_pw[k], l_addr[k], l_data[k]);
        pend[k] = 1'b0; ack_end[k] = edge_n + 1;
      end
    end else if (cyc && stb) begin
      if (WS[k] == 0) begin
        commit_m(k, we, pw, addr, wdat);
        ack_end[k] = edge_n + 1;
      end else begin
        l_we[k] = we; l_pw[k] = pw; l_addr[k] = addr; l_data[k] = wdat;
        pend[k] = 1'b1; t0[k] = edge_n;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      inited[k] = 1'b0; pend[k] = 1'b0; ack_end[k] = -1; m_dk[k] = 1'b0;
      for (int a = 0; a < 256; a++) mk[k][a] = 1'b0;
    end
    forever begin
      @(posedge clk);
      edge_n++;
      for (int k = 0; k < 3; k++) model_step(k);
    end
  end

  // Every-cycle compare against the model on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (inited[k]) begin
        chk("ack", k, 16'(ack[k]), 16'(ack_end[k] != -1));
        chk("busy", k, 16'(busy[k]), 16'(pend[k] || (ack_end[k] != -1)));
        chk("port", k, pout[k], m_port[k]);
        if (m_dk[k]) chk("data", k, dout[k], m_dout[k]);
      end
    end
  end

  task automatic drv(input bit c, input bit s, input bit w, input bit p, input logic [7:0] a, input logic [15:0] d);
    cyc = c; stb = s; we = w; pw = p; addr = a; wdat = d;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 8'h00, 16'h0000);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(input int k, input int maxc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      tick();
      if (ack[k]) ok = 1'b1;
    end
    chk("ack_wait", k, 16'(ok), 16'h1);
  endtask

  initial begin
    int hold, gap;
    rst = 1'b0; idle();
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_ack", k, 16'(ack[k]), 16'h0);
      chk("rst_busy", k, 16'(busy[k]), 16'h0);
      chk("rst_data", k, dout[k], 16'h0);
      chk("rst_port", k, pout[k], 16'h0);
    end
    rst = 1'b1;
    tick();

    // One wait state: write BEEF@05, ack in the cycle after T0+1, one cycle wide.
    drv(1, 1, 1, 0, 8'h05, 16'hBEEF);
    tick();
    chk("ws1_ack_t0", 0, 16'(ack[0]), 16'h0);
    chk("ws1_busy_t0", 0, 16'(busy[0]), 16'h1);
    chk("ws0_ack_t0", 1, 16'(ack[1]), 16'h1);
    tick();
    chk("ws1_ack_t1", 0, 16'(ack[0]), 16'h1);
    idle();
    tick();
    chk("ws1_ack_t2", 0, 16'(ack[0]), 16'h0);
    chk("ws1_busy_t2", 0, 16'(busy[0]), 16'h0);
    drv(1, 1, 0, 0, 8'h05, 16'h0);
    tick();
    chk("ws0_rd", 1, dout[1], 16'hBEEF);
    tick();
    chk("ws1_rd_ack", 0, 16'(ack[0]), 16'h1);
    chk("ws1_rd", 0, dout[0], 16'hBEEF);
    idle(); tick();

    // Zero wait states: back-to-back request leaves one idle cycle between acks.
    drv(1, 1, 1, 0, 8'h00, 16'h1234);
    tick();
    chk("ws0_wr_ack", 1, 16'(ack[1]), 16'h1);
    drv(1, 1, 0, 0, 8'h00, 16'h0);
    tick();
    chk("ws0_gap", 1, 16'(ack[1]), 16'h0);
    tick();
    chk("ws0_rd_ack", 1, 16'(ack[1]), 16'h1);
    chk("ws0_rd_data", 1, dout[1], 16'h1234);
    idle(); tick(); tick();

    // Abort with three wait states.
    drv(1, 1, 1, 0, 8'h0A, 16'h1111);
    wait_ack(2, 10);
    idle(); tick(); tick();
    drv(1, 1, 1, 0, 8'h0A, 16'hAAAA);
    tick();
    idle();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_noack", 2, 16'(ack[2]), 16'h0);
    end
    drv(1, 1, 0, 0, 8'h0A, 16'h0);
    wait_ack(2, 10);
    chk("abort_rd", 2, dout[2], 16'h1111);
    idle(); tick(); tick();

    // Out of range on the 16-word instance.
    drv(1, 1, 1, 0, 8'h20, 16'h5555);
    wait_ack(2, 10);
    idle(); tick(); tick();
    drv(1, 1, 0, 0, 8'h20, 16'h0);
    wait_ack(2, 10);
    chk("oor_rd", 2, dout[2], 16'h0000);
    idle(); tick(); tick();

    // Reset during WAIT: outputs clear, write never lands.
    drv(1, 1, 1, 0, 8'h0A, 16'h7777);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 3; k += 2) begin
      chk("mid_rst_ack", k, 16'(ack[k]), 16'h0);
      chk("mid_rst_busy", k, 16'(busy[k]), 16'h0);
      chk("mid_rst_data", k, dout[k], 16'h0);
    end
    rst = 1'b1; idle(); tick();
    drv(1, 1, 0, 0, 8'h0A, 16'h0);
    wait_ack(2, 10);
    chk("mid_rst_rd", 2, dout[2], 16'h1111);
    idle(); tick(); tick();

    // Port access.
    drv(1, 1, 1, 1, 8'h0A, 16'h00F0);
    wait_ack(2, 10);
    idle(); tick(); tick();
    chk("port_wr", 2, pout[2], PORT_EN ? 16'h00F0 : 16'h0000);
    drv(1, 1, 0, 1, 8'h0A, 16'h0);
    wait_ack(2, 10);
    chk("port_rd", 2, dout[2], 16'h00F0);
    idle(); tick(); tick();
    drv(1, 1, 0, 0, 8'h0A, 16'h0);
    wait_ack(2, 10);
    chk("port_ram", 2, dout[2], PORT_EN ? 16'h1111 : 16'h00F0);
    idle(); tick(); tick();

    // Randomized bus traffic, model-checked every cycle.
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(39) == 0) begin
        rst = 1'b0;
        repeat ($urandom_range(2, 1)) tick();
        rst = 1'b1;
      end
      drv($urandom_range(9) != 0, $urandom_range(7) != 0, 1'($urandom), $urandom_range(3) == 0,
          ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(23)), 16'($urandom));
      hold = $urandom_range(6, 1);
      repeat (hold) tick();
      idle();
      gap = $urandom_range(2);
      repeat (gap) tick();
    end
    idle();
    repeat (6) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
